alu: RTL and testbench

Sequential arithmetic/logic unit for the 8-bit datapath, sitting directly downstream of the register bank. It takes its two operands from the register bank's two read ports (`reg_1_out` → `operand_a`, `reg_2_out` → `operand_b`) and drives `result` back to the register bank's `reg_data_in`. It also keeps a status-flag register (Z, C, N, V). Single-cycle ops complete in one clock. MUL is a multi-cycle shift-add unit behind a start/busy/done handshake.

---
 rtl/alu.sv | 182 ++++++++++++++++++
 tb/tb_alu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit sequential ALU with Z/C/N/V status flags. Single-cycle ops finish in one
// clock; MUL is an unsigned shift-add unit behind a start/busy/done handshake.
module alu #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic [DATA_BUS_WIDTH-1:0] operand_a,
  input  logic [DATA_BUS_WIDTH-1:0] operand_b,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [DATA_BUS_WIDTH-1:0] result_high,
  output logic                      busy,
  output logic                      done,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      flag_n,
  output logic                      flag_v
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  localparam logic signed [W:0] S_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] S_MIN = {2'b11, {(W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_MUL = 4'hF;

  logic [1:0]     state;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [W-1:0]          arith_b;
  logic                  arith_cin;
  logic                  arith_sub;
  logic [W:0]            u_r;
  logic signed [W:0]     s_a;
  logic signed [W:0]     s_b;
  logic signed [W:0]     s_cin;
  logic signed [W:0]     s_r;
  logic [W-1:0]          res_c;
  logic                  c_c;
  logic                  v_c;
  logic                  wr_res;

  // INC/DEC reuse the adder with a constant one; ADC/SBC feed the old carry in.
  always_comb begin
    arith_b   = operand_b;
    arith_cin = 1'b0;
    arith_sub = 1'b0;
    case (op)
      OP_ADC:         arith_cin = flag_c;
      OP_SUB, OP_CMP: arith_sub = 1'b1;
      OP_SBC: begin
        arith_sub = 1'b1;
        arith_cin = flag_c;
      end
      OP_INC: arith_b = {{(W-1){1'b0}}, 1'b1};
      OP_DEC: begin
        arith_b   = {{(W-1){1'b0}}, 1'b1};
        arith_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign u_r   = arith_sub ? ({1'b0, operand_a} - {1'b0, arith_b} - {{W{1'b0}}, arith_cin})
                           : ({1'b0, operand_a} + {1'b0, arith_b} + {{W{1'b0}}, arith_cin});
  assign s_a   = {operand_a[W-1], operand_a};
  assign s_b   = {arith_b[W-1], arith_b};
  assign s_cin = {{W{1'b0}}, arith_cin};
  assign s_r   = arith_sub ? (s_a - s_b - s_cin) : (s_a + s_b + s_cin);

  // Bit W of the unsigned sum is carry on add and borrow on subtract.
  always_comb begin
    res_c  = u_r[W-1:0];
    c_c    = u_r[W];
    v_c    = (s_r > S_MAX) || (s_r < S_MIN);
    wr_res = 1'b1;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: ;
      OP_AND: begin res_c = operand_a & operand_b; c_c = flag_c; v_c = 1'b0; end
      OP_OR:  begin res_c = operand_a | operand_b; c_c = flag_c; v_c = 1'b0; end
      OP_XOR: begin res_c = operand_a ^ operand_b; c_c = flag_c; v_c = 1'b0; end
      OP_NOT: begin res_c = ~operand_a;            c_c = flag_c; v_c = 1'b0; end
      OP_SHL: begin res_c = {operand_a[W-2:0], 1'b0};   c_c = operand_a[W-1]; v_c = 1'b0; end
      OP_SHR: begin res_c = {1'b0, operand_a[W-1:1]};   c_c = operand_a[0];   v_c = 1'b0; end
      OP_ROL: begin res_c = {operand_a[W-2:0], flag_c}; c_c = operand_a[W-1]; v_c = 1'b0; end
      OP_ROR: begin res_c = {flag_c, operand_a[W-1:1]}; c_c = operand_a[0];   v_c = 1'b0; end
      OP_CMP: wr_res = 1'b0;
      default: ;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : {(2*W){1'b0}});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      result      <= '0;
      result_high <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_n      <= 1'b0;
      flag_v      <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand  <= {{W{1'b0}}, operand_a};
              mplier <= operand_b;
              acc    <= '0;
              cnt    <= '0;
              state  <= ST_MUL;
            end else begin
              if (wr_res) begin
                result      <= res_c;
                result_high <= '0;
              end
              flag_z <= (res_c == '0);
              flag_n <= res_c[W-1];
              flag_c <= c_c;
              flag_v <= v_c;
              state  <= ST_DONE;
            end
          end
        end
        // One partial product per edge; the last iteration publishes acc_nxt directly.
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            result      <= acc_nxt[W-1:0];
            result_high <= acc_nxt[2*W-1:W];
            flag_z      <= (acc_nxt == '0);
            flag_c      <= (acc_nxt[2*W-1:W] != '0);
            flag_n      <= acc_nxt[W-1];
            flag_v      <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a timestamp-based reference model checked every
// cycle, plus directed vectors with hand-computed expected outputs.
module tb_alu;

  localparam int W = 8;

  localparam logic [3:0] ADD = 4'h0, ADC = 4'h1, SUB = 4'h2, SBC = 4'h3;
  localparam logic [3:0] AND = 4'h4, OR  = 4'h5, XOR = 4'h6, NOT = 4'h7;
  localparam logic [3:0] SHL = 4'h8, SHR = 4'h9, ROL = 4'hA, ROR = 4'hB;
  localparam logic [3:0] INC = 4'hC, DEC = 4'hD, CMP = 4'hE, MUL = 4'hF;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [W-1:0] result;
  logic [W-1:0] result_high;
  logic         busy, done, flag_z, flag_c, flag_n, flag_v;

  always #5 clock = ~clock;

  alu #(.DATA_BUS_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .result_high(result_high),
    .busy(busy), .done(done),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string p, input int lo, input int hi,
                         input bit z, input bit c, input bit n, input bit v);
    chk({p, "_result"},      32'(result),      32'(lo));
    chk({p, "_result_high"}, 32'(result_high), 32'(hi));
    chk({p, "_z"}, 32'(flag_z), 32'(z));
    chk({p, "_c"}, 32'(flag_c), 32'(c));
    chk({p, "_n"}, 32'(flag_n), 32'(n));
    chk({p, "_v"}, 32'(flag_v), 32'(v));
  endtask

  function automatic int wrap8(input int x);
    return ((x % 256) + 256) % 256;
  endfunction

  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference semantics in plain integer arithmetic.
  function automatic void model_op(input int o, input int a, input int b, input bit c_old,
                                   input int lo_old, input int hi_old,
                                   output int lo, output int hi,
                                   output bit z, output bit c, output bit n, output bit v);
    int r, sr;
    bit arith;
    r = 0; sr = 0; arith = 1'b1; c = c_old; v = 1'b0; lo = 0; hi = 0; z = 1'b0; n = 1'b0;
    case (o)
      0:      begin r = a + b;         sr = sgn8(a) + sgn8(b);         c = (r > 255); end
      1:      begin r = a + b + c_old; sr = sgn8(a) + sgn8(b) + c_old; c = (r > 255); end
      2, 14:  begin r = a - b;         sr = sgn8(a) - sgn8(b);         c = (r < 0);   end
      3:      begin r = a - b - c_old; sr = sgn8(a) - sgn8(b) - c_old; c = (r < 0);   end
      4:      begin r = a & b;   arith = 1'b0; end
      5:      begin r = a | b;   arith = 1'b0; end
      6:      begin r = a ^ b;   arith = 1'b0; end
      7:      begin r = 255 - a; arith = 1'b0; end
      8:      begin r = a * 2;             c = (a >= 128);    arith = 1'b0; end
      9:      begin r = a / 2;             c = (a % 2 == 1);  arith = 1'b0; end
      10:     begin r = a * 2 + c_old;     c = (a >= 128);    arith = 1'b0; end
      11:     begin r = a / 2 + 128*c_old; c = (a % 2 == 1);  arith = 1'b0; end
      12:     begin r = a + 1; sr = sgn8(a) + 1; c = (r > 255); end
      13:     begin r = a - 1; sr = sgn8(a) - 1; c = (r < 0);   end
      default: begin
        r = a * b; lo = r % 256; hi = r / 256;
        z = (r == 0); c = (hi != 0); n = (lo >= 128); v = 1'b0;
        return;
      end
    endcase
    if (arith) v = (sr > 127) || (sr < -128);
    lo = wrap8(r);
    hi = 0;
    z  = (lo == 0);
    n  = (lo >= 128);
    if (o == 14) begin
      lo = lo_old;
      hi = hi_old;
    end
  endfunction

  // Model timeline: cycle k is the cycle following rising edge k.
  int cyc = 0, busy_s = -1, busy_e = -2, apply_at = -1, free_at = 0;
  int m_lo = 0, m_hi = 0;
  bit m_z = 1'b0, m_c = 1'b0, m_n = 1'b0, m_v = 1'b0;

  initial begin
    int p_lo, p_hi, lat_m;
    bit p_z, p_c, p_n, p_v;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        busy_s = -1; busy_e = -2; apply_at = -1; free_at = 0;
        m_lo = 0; m_hi = 0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
      end else begin
        cyc++;
        if (cyc >= free_at && start === 1'b1) begin
          model_op(int'(op), int'(operand_a), int'(operand_b), m_c, m_lo, m_hi,
                   p_lo, p_hi, p_z, p_c, p_n, p_v);
          lat_m    = (op == MUL) ? W + 1 : 1;
          busy_s   = cyc;
          busy_e   = cyc + lat_m - 1;
          apply_at = busy_e;
          free_at  = cyc + lat_m + 1;
        end
        if (cyc == apply_at) begin
          m_lo = p_lo; m_hi = p_hi; m_z = p_z; m_c = p_c; m_n = p_n; m_v = p_v;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noisy, output int lat_o, output int busy_o);
    bit got;
    got = 1'b0; lat_o = 0; busy_o = 0;
    @(negedge clock); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clock);
      if (busy) busy_o++;
      if (done) begin
        got = 1'b1;
        lat_o = i;
      end else if (noisy) begin
        #1;
        start     = 1'($urandom_range(0, 1));
        op        = 4'($urandom_range(0, 15));
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    if (noisy) begin
      #1;
      start = 1'b0;
    end
  endtask

  logic [3:0]   t_op [13] = '{XOR, OR, NOT, SHR, ROL, SBC, DEC, DEC, ADC, ADD, SHL, MUL, INC};
  logic [W-1:0] t_a  [13] = '{8'hA5, 8'h0F, 8'h55, 8'h03, 8'h80, 8'h10, 8'h80, 8'h00, 8'h7F, 8'h80, 8'h40, 8'h00, 8'hFF};
  logic [W-1:0] t_b  [13] = '{8'hFF, 8'h30, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h37, 8'h00};

  bit cmp_en = 1'b0;

  initial begin
    int lat, bcnt, dn;

    fork
      begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
          @(negedge clock);
          if (cmp_en) begin
            chk("busy",        32'(busy), 32'(cyc >= busy_s && cyc <= busy_e));
            chk("done",        32'(done), 32'(cyc == apply_at));
            chk("done_twice",  32'(done & prev_done), 32'd0);
            chk("result",      32'(result),      32'(m_lo));
            chk("result_high", 32'(result_high), 32'(m_hi));
            chk("flag_z", 32'(flag_z), 32'(m_z));
            chk("flag_c", 32'(flag_c), 32'(m_c));
            chk("flag_n", 32'(flag_n), 32'(m_n));
            chk("flag_v", 32'(flag_v), 32'(m_v));
          end
          prev_done = done;
        end
      end
    join_none

    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    #1;
    reset  = 1'b1;
    cmp_en = 1'b1;

    run_op(ADD, 8'hFF, 8'h01, 1'b0, lat, bcnt);
    chk("add_latency", 32'(lat), 32'd1);
    chk("add_busy_cycles", 32'(bcnt), 32'd1);
    chk_out("add", 8'h00, 0, 1, 1, 0, 0);
    run_op(ADC, 8'h10, 8'h20, 1'b0, lat, bcnt);
    chk_out("adc", 8'h31, 0, 0, 0, 0, 0);

    run_op(SUB, 8'h80, 8'h01, 1'b0, lat, bcnt);
    chk_out("sub_ovf", 8'h7F, 0, 0, 0, 0, 1);
    run_op(SUB, 8'h01, 8'h02, 1'b0, lat, bcnt);
    chk_out("sub_borrow", 8'hFF, 0, 0, 1, 1, 0);
    run_op(CMP, 8'h05, 8'h05, 1'b0, lat, bcnt);
    chk_out("cmp", 8'hFF, 0, 1, 0, 0, 0);

    run_op(SUB, 8'h00, 8'h01, 1'b0, lat, bcnt);
    chk_out("sub_setc", 8'hFF, 0, 0, 1, 1, 0);
    run_op(ROR, 8'h02, 8'h00, 1'b0, lat, bcnt);
    chk_out("ror", 8'h81, 0, 0, 0, 1, 0);
    run_op(SHL, 8'h81, 8'h00, 1'b0, lat, bcnt);
    chk_out("shl", 8'h02, 0, 0, 1, 0, 0);
    run_op(AND, 8'hF0, 8'h0F, 1'b0, lat, bcnt);
    chk_out("and", 8'h00, 0, 1, 1, 0, 0);

    run_op(MUL, 8'hFF, 8'hFF, 1'b1, lat, bcnt);
    chk("mul_latency", 32'(lat), 32'd9);
    chk("mul_busy_cycles", 32'(bcnt), 32'd9);
    chk_out("mul_ff", 8'h01, 8'hFE, 0, 1, 0, 0);

    // Abort a multiply after its fourth iteration.
    @(negedge clock); #1;
    start = 1'b1; op = MUL; operand_a = 8'hFF; operand_b = 8'h03;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_out("abort", 0, 0, 0, 0, 0, 0);
    @(negedge clock); #1;
    reset = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    run_op(MUL, 8'h03, 8'h04, 1'b0, lat, bcnt);
    chk("mul2_latency", 32'(lat), 32'd9);
    chk_out("mul_3x4", 8'h0C, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, lat, bcnt);
      chk("table_latency", 32'(lat), (t_op[i] == MUL) ? 32'd9 : 32'd1);
    end

    // start held high: a new op is accepted every second edge.
    @(negedge clock); #1;
    start = 1'b1; op = INC; operand_a = 8'h7F; operand_b = 8'h00;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) begin
        dn++;
        if (dn == 1) chk_out("inc_b2b", 8'h80, 0, 0, 0, 1, 1);
      end
    end
    chk("b2b_done_count", 32'(dn), 32'd4);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
